// File: rtl/hpm_counter_bank_pkg.sv
// Shared constants and types for the performance-counter bank: CSR address map,
// event-selector width and the per-counter event configuration record.
package hpm_pkg;

    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_MHPMCNT_BASE  = 12'hB03;
    localparam logic [11:0] CSR_MHPMCNTH_BASE = 12'hB83;
    localparam logic [11:0] CSR_MHPMEVT_BASE  = 12'h323;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;

    localparam int SEL_W = 8;

    typedef struct packed {
        logic             of;
        logic [SEL_W-1:0] sel;
    } hpm_evt_cfg_t;

    // Low-half CSR address of counter slot idx (0 = mcycle, 1 = minstret, 2+ = mhpmcounter3+)
    function automatic logic [11:0] cnt_lo_addr(input int unsigned idx);
        if (idx == 0) begin
            return CSR_MCYCLE;
        end else begin
            return CSR_MCYCLE + 12'(idx + 1);
        end
    endfunction

endpackage

// File: rtl/hpm_counter_bank_if.sv
// Machine-mode CSR access port of the performance-counter bank.
interface hpm_counter_bank_if;
    logic        we;
    logic        re;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        hit;

    modport master (output we, re, addr, wdata, input rdata, rvalid, hit);
    modport slave  (input we, re, addr, wdata, output rdata, rvalid, hit);
endinterface

// File: rtl/hpm_counter_bank_counter.sv
// One W-bit counter with split 32-bit low/high writes, increment enable and
// wrap detection; a CSR write in the same cycle takes precedence over the increment.
module hpm_counter
    import hpm_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_en,
    input  logic         wr_lo,
    input  logic         wr_hi,
    input  logic [31:0]  wdata,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    logic [W-1:0] cnt_r;
    logic [W-1:0] cnt_nxt_s;

    // Next value: each written half is replaced, otherwise count up modulo 2^W
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (wr_lo || wr_hi) begin
            if (wr_lo) begin
                cnt_nxt_s[31:0] = wdata;
            end else begin
                cnt_nxt_s[31:0] = cnt_r[31:0];
            end
            if (wr_hi) begin
                cnt_nxt_s[W-1:32] = wdata[W-33:0];
            end else begin
                cnt_nxt_s[W-1:32] = cnt_r[W-1:32];
            end
        end else if (inc_en) begin
            cnt_nxt_s = cnt_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Counter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign cnt  = cnt_r;
    assign wrap = inc_en & ~(wr_lo | wr_hi) & (&cnt_r);

endmodule

// File: rtl/hpm_counter_bank.sv
// Bank of mcycle, minstret and NUM_HPM programmable counters behind a registered CSR port.
// Define HPM_OVF_IRQ_EN to add sticky per-counter overflow flags and the irq_ovf request.
module hpm_counter_bank
    import hpm_pkg::*;
#(
    parameter int NUM_HPM    = 4,
    parameter int CNT_WIDTH  = 64,
    parameter int NUM_EVENTS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  incr_instr,
    input  logic [NUM_EVENTS-1:0] event_vec,
    hpm_counter_bank_if.slave     csr,
    output logic                  irq_ovf
);

    localparam int          NC       = NUM_HPM + 2;
    localparam logic [31:0] INH_MASK = (((32'd1 << NUM_HPM) - 32'd1) << 2) | 32'd1;

    logic [CNT_WIDTH-1:0]       cnt_s     [NC];
    logic [63:0]                cnt_ext_s [NC];
    logic [NC-1:0]              inc_en_s;
    logic [NC-1:0]              wr_lo_s;
    logic [NC-1:0]              wr_hi_s;
    logic [NC-1:0]              wrap_s;
    logic [NUM_HPM-1:0]         evt_wr_s;
    logic [NUM_HPM-1:0]         of_nxt_s;
    logic                       inh_wr_s;
    logic                       hit_s;
    logic [31:0]                rd_mux_s;
    logic [255:0]               ev_pad_s;
    hpm_evt_cfg_t [NUM_HPM-1:0] evt_cfg_r;
    hpm_evt_cfg_t [NUM_HPM-1:0] evt_cfg_nxt_s;
    logic [31:0]                inhibit_r;
    logic [31:0]                rdata_r;
    logic                       rvalid_r;
    logic                       irq_r;
    logic                       wrap_unused_s;

    for (genvar g = 0; g < NC; g++) begin : g_cnt
        hpm_counter #(.W(CNT_WIDTH)) u_cnt (
            .clk    (clk),
            .rst_n  (rst_n),
            .inc_en (inc_en_s[g]),
            .wr_lo  (wr_lo_s[g]),
            .wr_hi  (wr_hi_s[g]),
            .wdata  (csr.wdata),
            .cnt    (cnt_s[g]),
            .wrap   (wrap_s[g])
        );
        assign cnt_ext_s[g] = 64'(cnt_s[g]);
    end

    // Increment enables, evaluated with the inhibit/selector values held this cycle
    always_comb begin
        ev_pad_s                   = '0;
        ev_pad_s[NUM_EVENTS-1:0]   = event_vec;
        inc_en_s                   = '0;
        inc_en_s[0]                = ~inhibit_r[0];
        inc_en_s[1]                = incr_instr;
        for (int i = 0; i < NUM_HPM; i++) begin
            if ((evt_cfg_r[i].sel != 8'd0) && (32'(evt_cfg_r[i].sel) <= 32'(NUM_EVENTS))) begin
                inc_en_s[i+2] = ~inhibit_r[i+2] & ev_pad_s[evt_cfg_r[i].sel - 8'd1];
            end else begin
                inc_en_s[i+2] = 1'b0;
            end
        end
    end

    // Address decode: AND-OR read mux and per-register write strobes
    always_comb begin
        hit_s    = 1'b0;
        rd_mux_s = 32'd0;
        wr_lo_s  = '0;
        wr_hi_s  = '0;
        evt_wr_s = '0;
        for (int c = 0; c < NC; c++) begin
            wr_lo_s[c] = csr.we & (csr.addr == cnt_lo_addr(c));
            wr_hi_s[c] = csr.we & (csr.addr == (cnt_lo_addr(c) + 12'h080));
            hit_s      = hit_s | (csr.addr == cnt_lo_addr(c)) | (csr.addr == (cnt_lo_addr(c) + 12'h080));
            rd_mux_s   = rd_mux_s
                       | ({32{csr.addr == cnt_lo_addr(c)}} & cnt_ext_s[c][31:0])
                       | ({32{csr.addr == (cnt_lo_addr(c) + 12'h080)}} & cnt_ext_s[c][63:32]);
        end
        for (int i = 0; i < NUM_HPM; i++) begin
            evt_wr_s[i] = csr.we & (csr.addr == (CSR_MHPMEVT_BASE + 12'(i)));
            hit_s       = hit_s | (csr.addr == (CSR_MHPMEVT_BASE + 12'(i)));
            rd_mux_s    = rd_mux_s | ({32{csr.addr == (CSR_MHPMEVT_BASE + 12'(i))}}
                        & {evt_cfg_r[i].of, 23'd0, evt_cfg_r[i].sel});
        end
        inh_wr_s = csr.we & (csr.addr == CSR_MCOUNTINHIBIT);
        hit_s    = hit_s | (csr.addr == CSR_MCOUNTINHIBIT);
        rd_mux_s = rd_mux_s | ({32{csr.addr == CSR_MCOUNTINHIBIT}} & inhibit_r);
    end

    // Selector/OF next state; a CSR write overrides an overflow in the same cycle
    always_comb begin
        evt_cfg_nxt_s = evt_cfg_r;
        of_nxt_s      = '0;
        for (int i = 0; i < NUM_HPM; i++) begin
            if (evt_wr_s[i]) begin
                evt_cfg_nxt_s[i].sel = csr.wdata[SEL_W-1:0];
`ifdef HPM_OVF_IRQ_EN
                evt_cfg_nxt_s[i].of  = csr.wdata[31];
            end else if (wrap_s[i+2]) begin
                evt_cfg_nxt_s[i].of  = 1'b1;
`endif
            end else begin
                evt_cfg_nxt_s[i] = evt_cfg_r[i];
            end
            of_nxt_s[i] = evt_cfg_nxt_s[i].of;
        end
    end

`ifdef HPM_OVF_IRQ_EN
    assign wrap_unused_s = ^wrap_s[1:0];
`else
    assign wrap_unused_s = ^wrap_s;
`endif

    // Configuration, read-port and interrupt registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_cfg_r <= '0;
            inhibit_r <= 32'd0;
            rdata_r   <= 32'd0;
            rvalid_r  <= 1'b0;
            irq_r     <= 1'b0;
        end else begin
            evt_cfg_r <= evt_cfg_nxt_s;
            if (inh_wr_s) begin
                inhibit_r <= csr.wdata & INH_MASK;
            end
            rvalid_r <= csr.re;
            if (csr.re) begin
                rdata_r <= rd_mux_s;
            end
            irq_r <= |of_nxt_s;
        end
    end

    assign csr.rdata  = rdata_r;
    assign csr.rvalid = rvalid_r;
    assign csr.hit    = hit_s;
    assign irq_ovf    = irq_r;

endmodule
